// File: rtl/wm8731_config_sequencer_pkg.sv
// WM8731 register map, init table constants and FSM encoding
// shared by the configuration sequencer and its init ROM.
package wm8731_config_sequencer_pkg;

    localparam logic [6:0] R0_LLINEIN   = 7'h00;
    localparam logic [6:0] R1_RLINEIN   = 7'h01;
    localparam logic [6:0] R2_LHPOUT    = 7'h02;
    localparam logic [6:0] R3_RHPOUT    = 7'h03;
    localparam logic [6:0] R4_ANAPATH   = 7'h04;
    localparam logic [6:0] R5_DIGPATH   = 7'h05;
    localparam logic [6:0] R6_PWRDOWN   = 7'h06;
    localparam logic [6:0] R7_IFACE     = 7'h07;
    localparam logic [6:0] R8_SAMPLING  = 7'h08;
    localparam logic [6:0] R9_ACTIVE    = 7'h09;
    localparam logic [6:0] R15_RESET    = 7'h0F;

    localparam logic [6:0] I2C_SLAVE_ADDR = 7'h1A;

    localparam int LRHPBOTH = 8;
    localparam int LZCEN    = 7;

    localparam int INIT_LEN = 11;
    localparam int IDX_W    = 4;

    localparam logic [8:0] D_RESET     = 9'h000;
    localparam logic [8:0] D_PWR_OFF   = 9'h010;
    localparam logic [8:0] D_LINEIN    = 9'h017;
    localparam logic [8:0] D_ANAPATH   = 9'h012;
    localparam logic [8:0] D_DIGPATH   = 9'h000;
    localparam logic [8:0] D_IFACE     = 9'h042;
    localparam logic [8:0] D_SAMPLING  = 9'h000;
    localparam logic [8:0] D_ACTIVE    = 9'h001;
    localparam logic [8:0] D_PWR_ON    = 9'h000;

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_LOAD,
        S_REQ,
        S_WAIT,
        S_BACKOFF,
        S_IDLE,
        S_FAIL
    } state_t;

    // Headphone volume write: both channels, zero-cross detect off.
    function automatic logic [15:0] hp_vol_word(input logic [6:0] vol);
        logic [8:0] d;
        d           = '0;
        d[LRHPBOTH] = 1'b1;
        d[LZCEN]    = 1'b0;
        d[6:0]      = vol;
        return {R2_LHPOUT, d};
    endfunction

endpackage

// File: rtl/wm8731_config_sequencer_if.sv
// Request/done handshake between the config sequencer
// and the shared I2C master.
interface wm8731_config_sequencer_if;

    logic        I2C_XFER_REQ;
    logic [15:0] I2C_XFER_DATA;
    logic        I2C_XFER_DONE;
    logic        I2C_XFER_NACK;

    modport master (
        output I2C_XFER_REQ,
        output I2C_XFER_DATA,
        input  I2C_XFER_DONE,
        input  I2C_XFER_NACK
    );

    modport slave (
        input  I2C_XFER_REQ,
        input  I2C_XFER_DATA,
        output I2C_XFER_DONE,
        output I2C_XFER_NACK
    );

endinterface

// File: rtl/wm8731_init_rom.sv
// Power-up register table for the WM8731: index in,
// {reg_addr, reg_data} word out, purely combinational.
module wm8731_init_rom
    import wm8731_config_sequencer_pkg::*;
#(
    parameter logic [6:0] DEFAULT_VOLUME = 7'h79
) (
    input  logic [IDX_W-1:0] index,
    output logic [15:0]      word
);

    // Table lookup; unused indices read as zero.
    always_comb begin
        word = '0;
        unique case (index)
            4'd0:    word = {R15_RESET, D_RESET};
            4'd1:    word = {R6_PWRDOWN, D_PWR_OFF};
            4'd2:    word = {R0_LLINEIN, D_LINEIN};
            4'd3:    word = {R1_RLINEIN, D_LINEIN};
            4'd4:    word = hp_vol_word(DEFAULT_VOLUME);
            4'd5:    word = {R4_ANAPATH, D_ANAPATH};
            4'd6:    word = {R5_DIGPATH, D_DIGPATH};
            4'd7:    word = {R7_IFACE, D_IFACE};
            4'd8:    word = {R8_SAMPLING, D_SAMPLING};
            4'd9:    word = {R9_ACTIVE, D_ACTIVE};
            4'd10:   word = {R6_PWRDOWN, D_PWR_ON};
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/wm8731_config_sequencer.sv
// Writes the WM8731 power-up table over I2C with bounded
// NACK retry, then services headphone volume updates.
module wm8731_config_sequencer
    import wm8731_config_sequencer_pkg::*;
#(
    parameter int unsigned POWER_ON_DELAY = 1000000,
    parameter int unsigned RETRY_DELAY    = 5000,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter logic [6:0]  DEFAULT_VOLUME = 7'h79
) (
    input  logic                              CLK,
    input  logic                              RESET,
    wm8731_config_sequencer_if.master         i2c,
    input  logic                              VOL_UPDATE_REQ,
    input  logic [6:0]                        VOL_LEVEL,
    output logic                              CONFIG_DONE,
    output logic                              CONFIG_ERROR,
    output logic                              BUSY
);

    localparam int DLY_MAX = (POWER_ON_DELAY > RETRY_DELAY) ?
                             int'(POWER_ON_DELAY) : int'(RETRY_DELAY);
    localparam int DLY_W   = (DLY_MAX > 2) ? $clog2(DLY_MAX) : 1;
    localparam int RTY_W   = (MAX_RETRIES > 0) ?
                             $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [DLY_W-1:0] PWR_LAST = DLY_W'(POWER_ON_DELAY - 1);
    localparam logic [DLY_W-1:0] BKO_LAST = DLY_W'(RETRY_DELAY - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INIT_LEN - 1);

    state_t           state, state_n;
    logic [DLY_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [RTY_W-1:0] retry, retry_n;
    logic             req, req_n;
    logic [15:0]      data, data_n;
    logic             done_r, done_n;
    logic             err_r, err_n;
    logic [6:0]       vol_latch, vol_latch_n;
    logic             vol_pend, vol_pend_n;
    logic [15:0]      rom_word;

    wm8731_init_rom #(
        .DEFAULT_VOLUME(DEFAULT_VOLUME)
    ) u_rom (
        .index(idx),
        .word (rom_word)
    );

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_PWR_WAIT;
            cnt       <= '0;
            idx       <= '0;
            retry     <= '0;
            req       <= 1'b0;
            data      <= '0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            vol_latch <= '0;
            vol_pend  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            retry     <= retry_n;
            req       <= req_n;
            data      <= data_n;
            done_r    <= done_n;
            err_r     <= err_n;
            vol_latch <= vol_latch_n;
            vol_pend  <= vol_pend_n;
        end
    end

    // Next-state, counters, handshake and volume latch.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        retry_n     = retry;
        req_n       = req;
        data_n      = data;
        done_n      = done_r;
        err_n       = err_r;
        vol_latch_n = vol_latch;
        vol_pend_n  = vol_pend;

        unique case (state)
            S_PWR_WAIT: begin
                if (cnt == PWR_LAST) begin
                    cnt_n   = '0;
                    state_n = S_LOAD;
                end else begin
                    cnt_n = cnt + DLY_W'(1);
                end
            end
            S_LOAD: begin
                data_n  = rom_word;
                retry_n = '0;
                state_n = S_REQ;
            end
            S_REQ: begin
                req_n   = 1'b1;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (i2c.I2C_XFER_DONE) begin
                    req_n = 1'b0;
                    if (!i2c.I2C_XFER_NACK) begin
                        if (done_r) begin
                            state_n = S_IDLE;
                        end else if (idx == IDX_LAST) begin
                            done_n  = 1'b1;
                            state_n = S_IDLE;
                        end else begin
                            idx_n   = idx + IDX_W'(1);
                            state_n = S_LOAD;
                        end
                    end else if (retry < RTY_MAX) begin
                        retry_n = retry + RTY_W'(1);
                        cnt_n   = '0;
                        state_n = S_BACKOFF;
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_FAIL;
                    end
                end
            end
            S_BACKOFF: begin
                if (cnt == BKO_LAST) begin
                    cnt_n   = '0;
                    state_n = S_REQ;
                end else begin
                    cnt_n = cnt + DLY_W'(1);
                end
            end
            S_IDLE: begin
                if (vol_pend) begin
                    data_n     = hp_vol_word(vol_latch);
                    retry_n    = '0;
                    vol_pend_n = 1'b0;
                    state_n    = S_REQ;
                end
            end
            S_FAIL: begin
                state_n = S_FAIL;
            end
            default: begin
                state_n = S_PWR_WAIT;
            end
        endcase

        // A new request wins over the clear in S_IDLE.
        if (VOL_UPDATE_REQ && (state != S_FAIL)) begin
            vol_latch_n = VOL_LEVEL;
            vol_pend_n  = 1'b1;
        end
    end

    assign i2c.I2C_XFER_REQ  = req;
    assign i2c.I2C_XFER_DATA = data;
    assign CONFIG_DONE       = done_r;
    assign CONFIG_ERROR      = err_r;
    assign BUSY              = !((state == S_IDLE) || (state == S_FAIL));

endmodule

// File: tb/tb_wm8731_config_sequencer.sv
// Self-checking bench: I2C slave model with scripted or random
// NACKs, transfer log and a write-list reference model.
module tb_wm8731_config_sequencer;

    localparam int PWR = 1000;
    localparam int RD  = 20;
    localparam int MR  = 3;
    localparam int LAT = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vol_req = 1'b0;
    logic [6:0] vol_level = '0;
    logic       cfg_done, cfg_err, busy;

    wm8731_config_sequencer_if bus();

    wm8731_config_sequencer #(
        .POWER_ON_DELAY(PWR),
        .RETRY_DELAY   (RD),
        .MAX_RETRIES   (MR),
        .DEFAULT_VOLUME(7'h79)
    ) dut (
        .CLK           (clk),
        .RESET         (rst),
        .i2c           (bus),
        .VOL_UPDATE_REQ(vol_req),
        .VOL_LEVEL     (vol_level),
        .CONFIG_DONE   (cfg_done),
        .CONFIG_ERROR  (cfg_err),
        .BUSY          (busy)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } xfer_t;
    xfer_t log_q[$];

    typedef struct {
        logic [6:0] addr;
        logic [8:0] val;
    } vec_t;
    vec_t tbl[11];

    bit          use_plan = 0;
    bit          plan[256];
    int          plan_ptr = 0;
    logic [15:0] nack_data = '0;
    int          nack_left = 0;
    bit          spur = 0;

    // Cycles since reset release, counted on the active edge.
    initial forever begin
        @(posedge clk);
        if (rst) cyc = 0;
        else cyc++;
    end

    // I2C master model: logs each REQ rise, answers LAT cycles later.
    initial begin
        bit pend;
        bit prev_req;
        int cnt;
        pend = 0;
        prev_req = 0;
        cnt = 0;
        bus.I2C_XFER_DONE = 1'b0;
        bus.I2C_XFER_NACK = 1'b0;
        forever begin
            @(negedge clk);
            bus.I2C_XFER_DONE = 1'b0;
            bus.I2C_XFER_NACK = 1'b0;
            if (rst) begin
                pend = 0;
                prev_req = 0;
            end else begin
                if (spur) begin
                    bus.I2C_XFER_DONE = 1'b1;
                    bus.I2C_XFER_NACK = 1'b1;
                    spur = 0;
                end else if (pend && !bus.I2C_XFER_REQ) begin
                    pend = 0;
                end else if (pend) begin
                    cnt++;
                    if (cnt == LAT) begin
                        bus.I2C_XFER_DONE = 1'b1;
                        pend = 0;
                        if (use_plan) begin
                            bus.I2C_XFER_NACK = plan[plan_ptr];
                            plan_ptr++;
                        end else if (bus.I2C_XFER_DATA == nack_data
                                     && nack_left > 0) begin
                            bus.I2C_XFER_NACK = 1'b1;
                            nack_left--;
                        end
                    end
                end
                if (bus.I2C_XFER_REQ && !prev_req) begin
                    log_q.push_back('{bus.I2C_XFER_DATA, cyc});
                    pend = 1;
                    cnt = 0;
                end
                prev_req = bus.I2C_XFER_REQ;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ld(input int i);
        if (i < log_q.size()) return {16'h0, log_q[i].data};
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int lc(input int i);
        if (i < log_q.size()) return log_q[i].cyc;
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        log_q.delete();
        plan_ptr = 0;
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        for (int i = 0; i < budget && busy !== 1'b0; i++) @(negedge clk);
        chk(nm, {31'h0, busy}, 32'h0);
    endtask

    task automatic wait_log(input int n, input int budget, input string nm);
        for (int i = 0; i < budget && log_q.size() < n; i++) @(negedge clk);
        chk(nm, {31'h0, log_q.size() >= n}, 32'h1);
    endtask

    task automatic pulse_vol(input logic [6:0] v);
        vol_level = v;
        vol_req = 1'b1;
        @(negedge clk);
        vol_req = 1'b0;
    endtask

    // Expected REQ data sequence: 11 table writes then one volume
    // write, each retried on NACK until MR retries are used up.
    function automatic void model(input bit np[256], input logic [6:0] vol,
                                  output logic [15:0] eq[$],
                                  output bit e_err, output bit e_done);
        int k;
        k = 0;
        eq = {};
        e_err = 0;
        e_done = 0;
        for (int w = 0; w < 12 && !e_err; w++) begin
            logic [15:0] word;
            int tries;
            bit ok;
            word = (w < 11) ? {tbl[w].addr, tbl[w].val}
                            : {7'h02, 2'b10, vol};
            tries = 0;
            ok = 0;
            while (!ok && !e_err) begin
                eq.push_back(word);
                if (!np[k]) ok = 1;
                else begin
                    tries++;
                    if (tries > MR) e_err = 1;
                end
                k++;
            end
            if (w == 10 && ok) e_done = 1;
        end
    endfunction

    initial begin
        logic [15:0] eq[$];
        bit e_err, e_done;
        int c0;
        logic [6:0] rv;

        tbl[0]  = '{7'h0F, 9'h000};
        tbl[1]  = '{7'h06, 9'h010};
        tbl[2]  = '{7'h00, 9'h017};
        tbl[3]  = '{7'h01, 9'h017};
        tbl[4]  = '{7'h02, {2'b10, 7'h79}};
        tbl[5]  = '{7'h04, 9'h012};
        tbl[6]  = '{7'h05, 9'h000};
        tbl[7]  = '{7'h07, 9'h042};
        tbl[8]  = '{7'h08, 9'h000};
        tbl[9]  = '{7'h09, 9'h001};
        tbl[10] = '{7'h06, 9'h000};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req", {31'h0, bus.I2C_XFER_REQ}, 0);
        chk("rst_data", {16'h0, bus.I2C_XFER_DATA}, 0);
        chk("rst_done", {31'h0, cfg_done}, 0);
        chk("rst_err", {31'h0, cfg_err}, 0);
        chk("rst_busy", {31'h0, busy}, 1);

        // Nominal init
        rst = 1'b0;
        wait_idle(20000, "nom_idle");
        chk("nom_count", log_q.size(), 11);
        chk("nom_first_cyc", lc(0), PWR + 2);
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("nom_data%0d", i), ld(i),
                {16'h0, tbl[i].addr, tbl[i].val});
            if (i > 0)
                chk($sformatf("nom_gap%0d", i), lc(i) - lc(i - 1), LAT + 3);
        end
        chk("nom_last", ld(10), 32'h0C00);
        chk("nom_cfg_done", {31'h0, cfg_done}, 1);
        chk("nom_err", {31'h0, cfg_err}, 0);

        // Stray DONE while idle
        spur = 1;
        repeat (10) @(negedge clk);
        chk("spur_count", log_q.size(), 11);
        chk("spur_busy", {31'h0, busy}, 0);
        chk("spur_err", {31'h0, cfg_err}, 0);

        // Volume update while idle
        c0 = cyc;
        pulse_vol(7'h7F);
        wait_log(12, 20, "vidle_req");
        chk("vidle_data", ld(11), 32'h057F);
        chk("vidle_lat", {31'h0, (lc(11) - c0) <= 3 && lc(11) > c0}, 1);
        repeat (3) @(negedge clk);
        wait_idle(200, "vidle_idle");
        chk("vidle_done", {31'h0, cfg_done}, 1);

        // Volume requests during init, last one wins
        do_reset();
        wait_log(5, 5000, "vinit_w4");
        pulse_vol(7'h50);
        wait_log(7, 5000, "vinit_w6");
        pulse_vol(7'h60);
        wait_log(12, 5000, "vinit_w12");
        repeat (5) @(negedge clk);
        wait_idle(500, "vinit_idle");
        repeat (100) @(negedge clk);
        chk("vinit_count", log_q.size(), 12);
        chk("vinit_last_init", ld(10), 32'h0C00);
        chk("vinit_vol", ld(11), 32'h0560);

        // Single NACK on index 7
        nack_data = 16'h0E42;
        nack_left = 1;
        do_reset();
        wait_idle(20000, "nack1_idle");
        chk("nack1_count", log_q.size(), 12);
        chk("nack1_a", ld(7), 32'h0E42);
        chk("nack1_b", ld(8), 32'h0E42);
        chk("nack1_gap", lc(8) - lc(7), LAT + RD + 2);
        chk("nack1_last", ld(11), 32'h0C00);
        chk("nack1_err", {31'h0, cfg_err}, 0);
        chk("nack1_done", {31'h0, cfg_done}, 1);

        // Persistent NACK on index 3
        nack_data = 16'h0217;
        nack_left = 1000;
        do_reset();
        wait_idle(20000, "nackp_idle");
        chk("nackp_count", log_q.size(), 7);
        for (int i = 3; i < 7; i++)
            chk($sformatf("nackp_data%0d", i), ld(i), 32'h0217);
        chk("nackp_err", {31'h0, cfg_err}, 1);
        chk("nackp_done", {31'h0, cfg_done}, 0);
        pulse_vol(7'h33);
        repeat (100) @(negedge clk);
        chk("nackp_vol_ignored", log_q.size(), 7);
        chk("nackp_busy", {31'h0, busy}, 0);
        nack_left = 0;

        // Reset mid-transfer at index 5
        do_reset();
        wait_log(6, 5000, "rmid_w5");
        chk("rmid_req_hi", {31'h0, bus.I2C_XFER_REQ}, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rmid_req_lo", {31'h0, bus.I2C_XFER_REQ}, 0);
        chk("rmid_done", {31'h0, cfg_done}, 0);
        chk("rmid_busy", {31'h0, busy}, 1);
        @(negedge clk);
        log_q.delete();
        rst = 1'b0;
        wait_log(1, 2000, "rmid_restart");
        chk("rmid_first", ld(0), 32'h1E00);
        chk("rmid_first_cyc", lc(0), PWR + 2);
        wait_idle(20000, "rmid_idle");

        // Reset during a volume write clears CONFIG_DONE
        pulse_vol(7'h11);
        wait_log(12, 20, "rvol_req");
        chk("rvol_pre_done", {31'h0, cfg_done}, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rvol_req_lo", {31'h0, bus.I2C_XFER_REQ}, 0);
        chk("rvol_done", {31'h0, cfg_done}, 0);

        // Random NACK patterns against the reference model
        use_plan = 1;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 256; k++)
                plan[k] = ($urandom_range(0, 3) == 0);
            rv = 7'($urandom_range(0, 127));
            model(plan, rv, eq, e_err, e_done);
            do_reset();
            wait_idle(20000, $sformatf("rnd%0d_idle", r));
            pulse_vol(rv);
            repeat (400) @(negedge clk);
            chk($sformatf("rnd%0d_count", r), log_q.size(), eq.size());
            for (int i = 0; i < eq.size(); i++)
                chk($sformatf("rnd%0d_data%0d", r, i), ld(i), {16'h0, eq[i]});
            chk($sformatf("rnd%0d_err", r), {31'h0, cfg_err}, {31'h0, e_err});
            chk($sformatf("rnd%0d_done", r), {31'h0, cfg_done}, {31'h0, e_done});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wm8731_config_sequencer.md
Name: wm8731_config_sequencer

Overview:
- Configures the WM8731 audio codec after power-up by sequencing a fixed table of register writes through the shared I2C master, with bounded retry on NACK.
- Once configuration completes, services runtime headphone-volume update requests.
- Sits between the top-level power-on/switch logic and the I2C master, upstream of the DAC serializer and channel mixers.
- The downstream audio path stays muted until CONFIG_DONE is high.

Parameters:
- POWER_ON_DELAY, 1000000: CLK cycles to wait after reset before the first write (simulation uses 1000).
- RETRY_DELAY, 5000: CLK cycles idle between a NACKed transfer and its retry.
- MAX_RETRIES, 3: retries allowed per write after the first attempt; 0 means no retry.
- DEFAULT_VOLUME, 7'h79: headphone volume written during initial configuration.

Ports:
- CLK  in  1  system clock (50 MHz).
- RESET  in  1  synchronous, active-high reset.
- I2C_XFER_REQ  out  1  transfer request; held high until I2C_XFER_DONE.
- I2C_XFER_DATA  out  16  {reg_addr[6:0], reg_data[8:0]}; stable while REQ is high.
- I2C_XFER_DONE  in  1  one-cycle pulse from the I2C master marking the end of a transfer.
- I2C_XFER_NACK  in  1  sampled only when DONE=1; 1 = the slave NACKed.
- VOL_UPDATE_REQ  in  1  one-cycle pulse requesting a volume write.
- VOL_LEVEL  in  7  headphone volume code, sampled when VOL_UPDATE_REQ=1.
- CONFIG_DONE  out  1  initial table fully written; stays high until reset.
- CONFIG_ERROR  out  1  sticky; set when a write exhausts its retries.
- BUSY  out  1  high whenever the FSM is not in S_IDLE or S_FAIL.

Behaviour:
- Reset values: I2C_XFER_REQ=0, I2C_XFER_DATA=0, CONFIG_DONE=0, CONFIG_ERROR=0, BUSY=1, delay counter=0, table index=0, retry count=0, volume-pending flag=0.
- RESET asserted in any state, including mid-transfer, returns to S_PWR_WAIT on the next edge. REQ drops immediately; the I2C master must tolerate an abandoned request.
- Init table (index 0..10), entries as addr:data:
  - 0x0F:000 (codec reset)
  - 0x06:010 (outputs powered down)
  - 0x00:017, 0x01:017
  - 0x02:{2'b10, DEFAULT_VOLUME}
  - 0x04:012, 0x05:000
  - 0x07:042 (master mode, I2S, 16-bit)
  - 0x08:000
  - 0x09:001 (active)
  - 0x06:000 (outputs powered up)
- FSM states:
  - S_PWR_WAIT: count to POWER_ON_DELAY-1, then go to S_LOAD.
  - S_LOAD: drive I2C_XFER_DATA from table[index], clear retry count, go to S_REQ.
  - S_REQ: assert REQ, go to S_WAIT. REQ rises exactly one cycle after DATA is valid.
  - S_WAIT: hold REQ and DATA until DONE. On the DONE cycle, deassert REQ on the next edge, then:
    - ACK, index<10: index+1, go to S_LOAD.
    - ACK, index=10: set CONFIG_DONE, go to S_IDLE.
    - NACK, retry<MAX_RETRIES: retry+1, go to S_BACKOFF.
    - NACK, retries exhausted: set CONFIG_ERROR, go to S_FAIL.
  - S_BACKOFF: idle RETRY_DELAY cycles, then go to S_REQ with the same DATA.
  - S_IDLE: if the volume-pending flag is set, load {7'h02, 2'b10, vol_latch}, clear the flag, go to S_REQ. Completion returns to S_IDLE instead of advancing the index. NACK handling is the same as during init, so an exhausted volume write also goes to S_FAIL.
  - S_FAIL: terminal; only RESET exits.
- VOL_UPDATE_REQ in any non-fail state latches VOL_LEVEL into vol_latch and sets the pending flag.
  - Several requests before service: only the last value is written.
  - A request on the same cycle the flag clears in S_IDLE re-sets the flag with the new value.
  - Requests are ignored in S_FAIL.
- A DONE pulse outside S_WAIT is ignored.
- Counters are sized with $clog2 of their parameter, and must not wrap in the terminal states.
- Latency, no NACKs: first REQ rises POWER_ON_DELAY+2 cycles after reset release. Each write costs 3 cycles plus the I2C transfer time.

Decomposition:
- Shared package:
  - WM8731 register addresses (R0..R9, R15).
  - Init-table entries and table length (11).
  - Bit positions: LRHPBOTH=8, LZCEN=7.
  - I2C slave address 7'h1A, used by the I2C master.
- One sub-module: wm8731_init_rom, a combinational index-to-16-bit-word lookup, so the table is reusable and unit-testable.
- The FSM, counters and volume latch stay in the parent module.

Test Plan:
- Nominal: POWER_ON_DELAY=1000; bench I2C model ACKs every transfer with DONE 50 cycles after REQ.
  - First REQ at cycle 1002 with DATA=16'h1E00.
  - 11 transfers in table order; the last is DATA=16'h0C00.
  - CONFIG_DONE rises, BUSY falls.
- Single NACK on index 7: with RETRY_DELAY=20 and MAX_RETRIES=3, the same DATA 16'h0E42 is re-requested 20 cycles after the NACKed DONE. Sequence completes and CONFIG_ERROR stays 0.
- Persistent NACK on index 3: exactly 4 attempts of 16'h0217, then CONFIG_ERROR=1 and BUSY=0. No further REQ, even when VOL_UPDATE_REQ is pulsed.
- Volume during init: VOL_UPDATE_REQ with 7'h50 at index 4, then with 7'h60 at index 6. After CONFIG_DONE, exactly one extra transfer, DATA=16'h0560.
- Volume when idle: VOL_LEVEL=7'h7F pulse gives REQ within 3 cycles with DATA=16'h057F. After ACK, the FSM returns to S_IDLE with BUSY=0.
- Reset mid-transfer: RESET asserted while REQ is high at index 5 drops REQ on the next edge and clears CONFIG_DONE. After release, the sequence restarts from DATA=16'h1E00 after the power-on delay.
